mdu_seq: RTL

- Sequential multiply/divide responder that owns the HI/LO register pair.
- EX issues MULT/MULTU/DIV/DIVU/MTHI/MTLO requests with a Start/Busy/Done handshake and reads HI/LO directly for MFHI/MFLO.
- Replaces single-cycle 32x32 multiply and divide with a 32-iteration radix-2 datapath, so EX stalls on Busy instead of closing timing through a full divider.

---
 rtl/mdu_seq_pkg.sv | 34 +++
 rtl/mdu_seq.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/mdu_seq_pkg.sv
// Shared request codes, state encoding and helpers
// for the sequential multiply/divide unit.
package mdu_seq_pkg;

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    function automatic logic is_md_op(input logic [2:0] op);
        return op == OP_MULT || op == OP_MULTU ||
               op == OP_DIV  || op == OP_DIVU;
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return op == OP_DIV || op == OP_DIVU;
    endfunction

    function automatic logic is_signed_op(input logic [2:0] op);
        return op == OP_MULT || op == OP_DIV;
    endfunction

endpackage

// File: rtl/mdu_seq.sv
// Radix-2 sequential multiply/divide unit owning HI/LO.
// Multiply and divide share one 2*XLEN accumulator and counter.
module mdu_seq
    import mdu_seq_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int ITER = XLEN
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            Start,
    input  logic [2:0]      Op,
    input  logic [XLEN-1:0] Rs,
    input  logic [XLEN-1:0] Rt,
    output logic            Busy,
    output logic            Done,
    output logic [XLEN-1:0] HI,
    output logic [XLEN-1:0] LO
);

    localparam int CW = $clog2(ITER);

    state_t            state, state_n;
    logic [CW-1:0]     cnt;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   opb;
    logic              is_div;
    logic              neg_q;
    logic              neg_r;

    logic              sgn;
    logic              rs_neg;
    logic              rt_neg;
    logic [XLEN-1:0]   rs_abs;
    logic [XLEN-1:0]   rt_abs;
    logic              last;

    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_r;
    logic [XLEN:0]     div_sub;
    logic              div_ge;
    logic [XLEN-1:0]   rem_n;

    assign sgn    = is_signed_op(Op);
    assign rs_neg = sgn && Rs[XLEN-1];
    assign rt_neg = sgn && Rt[XLEN-1];
    assign rs_abs = rs_neg ? -Rs : Rs;
    assign rt_abs = rt_neg ? -Rt : Rt;
    assign last   = cnt == CW'(ITER - 1);

    // Multiply: add multiplicand into the upper half, then shift right.
    assign mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} +
                     {1'b0, acc[0] ? opb : {XLEN{1'b0}}};

    // Divide: upper half is the remainder, lower half shifts the
    // dividend out and the quotient in.
    assign div_r   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    assign div_sub = div_r - {1'b0, opb};
    assign div_ge  = div_r >= {1'b0, opb};
    assign rem_n   = div_ge ? div_sub[XLEN-1:0] : div_r[XLEN-1:0];

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE: begin
                if (Start && is_md_op(Op)) begin
                    if (is_div_op(Op) && Rt == '0)
                        state_n = S_FIX;
                    else
                        state_n = S_CALC;
                end
            end
            S_CALC: if (last) state_n = S_FIX;
            S_FIX:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state  <= S_IDLE;
            cnt    <= '0;
            acc    <= '0;
            opb    <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            Busy   <= 1'b0;
            Done   <= 1'b0;
            HI     <= '0;
            LO     <= '0;
        end else begin
            state <= state_n;
            Busy  <= state_n != S_IDLE;
            Done  <= state == S_FIX;
            unique case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (Start) begin
                        if (is_md_op(Op)) begin
                            is_div <= is_div_op(Op);
                            neg_q  <= rs_neg ^ rt_neg;
                            neg_r  <= rs_neg;
                            if (is_div_op(Op)) begin
                                acc <= {{XLEN{1'b0}}, rs_abs};
                                opb <= rt_abs;
                            end else begin
                                acc <= {{XLEN{1'b0}}, rt_abs};
                                opb <= rs_abs;
                            end
                        end else if (Op == OP_MTHI) begin
                            HI <= Rs;
                        end else if (Op == OP_MTLO) begin
                            LO <= Rs;
                        end
                    end
                end
                S_CALC: begin
                    cnt <= last ? '0 : cnt + 1'b1;
                    if (is_div)
                        acc <= {rem_n, acc[XLEN-2:0], div_ge};
                    else
                        acc <= {mul_sum, acc[XLEN-1:1]};
                end
                S_FIX: begin
                    // A zero divisor leaves HI/LO untouched.
                    if (is_div) begin
                        if (opb != '0) begin
                            LO <= neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
                            HI <= neg_r ? -acc[2*XLEN-1:XLEN]
                                        : acc[2*XLEN-1:XLEN];
                        end
                    end else begin
                        {HI, LO} <= neg_q ? -acc : acc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
